gpio_port_ctrl: RTL
===================

# gpio_port_ctrl

Parametrised, registered GPIO port: WIDTH bidirectional pins with per-pin direction, registered output data, a multi-stage input synchroniser, optional glitch filter, and per-pin edge-triggered interrupts with write-1-to-clear status. Sits between the SoC peripheral register decoder and the top-level pads. Replaces bare per-pin tristate buffering wherever firmware needs readback, interrupts or clean input sampling.

## Interface
- WIDTH, 8: number of pins (1..32)
- SYNC_STAGES, 2: input synchroniser depth (≥2)
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a filtered input changes (≥1; used only with GPIO_DEBOUNCE_EN)

- clk_i  input  1  single clock for all logic
- rst_i  input  1  synchronous, active-high reset
- dio_buf  inout  WIDTH  pad connections
- we_i  input  1  register write strobe, one write per cycle
- addr_i  input  3  register address for write and read
- wdata_i  input  WIDTH  write data
- rdata_o  output  WIDTH  read data, combinational from addr_i and registers
- irq_o  output  1  registered interrupt request, OR of (STATUS & IE)

## Operation
- Register map (addr_i):
  - 0 DOUT: R/W output data.
  - 1 DIR: R/W, 1 = input (pad tristated), 0 = output (pad driven with DOUT).
  - 2 IE: R/W interrupt enable.
  - 3 POL: R/W, 1 = rising edge, 0 = falling edge.
  - 4 STATUS: R, write-1-to-clear.
  - 5 DIN: RO filtered input value.
  - 6–7: read 0, writes ignored.
- Pad drive: dio_buf[i] = DIR[i] ? Z : DOUT[i]. DOUT and DIR take effect the cycle after the write.
- Input path, per bit:
  - dio_buf → SYNC_STAGES flops → sync value s.
  - s → filter → filtered value f.
  - f_prev is f delayed one cycle.
- Edge, per bit: edge[i] = DIR[i] & (POL[i] ? (f & ~f_prev) : (~f & f_prev)). Pins in output mode never set STATUS.
- STATUS update each cycle: STATUS_next = (STATUS & ~clr) | edge, where clr = wdata_i when (we_i and addr 4), else 0. When set and clear hit the same bit in the same cycle, set wins.
- irq_o is registered: irq_o <= |(STATUS_next & IE_next). A write to IE alone can raise or drop irq_o on the next edge.
- Reset values:
  - DOUT = 0, DIR = all 1, IE = 0, POL = all 1, STATUS = 0.
  - Synchroniser flops, f, f_prev, debounce counters = 0.
  - irq_o = 0, rdata_o reflects those values.
  - A reset asserted mid-operation discards pending filter counts and edges. No edge is reported from the reset-value transition.

## Timing
- Write to visible register: 1 cycle. rdata_o is valid in the same cycle as addr_i.
- Without GPIO_DEBOUNCE_EN, f = s:
  - A pad change is visible in DIN after SYNC_STAGES rising edges.
  - STATUS sets on the next edge (SYNC_STAGES+1).
  - irq_o rises on that same edge.
- With GPIO_DEBOUNCE_EN:
  - Add DEBOUNCE_CYCLES cycles to the above.
  - A pulse that shortens s to fewer than DEBOUNCE_CYCLES cycles never changes f.
- Clearing STATUS (W1C) while the edge condition is absent drops irq_o one cycle after the write, if no other enabled bits are set.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - One counter per bit, width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever s == f.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while s != f, then f <= s and the counter clears.
  - Counters saturate and never wrap.
- Undefined: no counters are instantiated, f = s, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset: assert rst_i for 2 cycles with the pads driven to random values. Required after reset: DIR reads 0xFF, POL reads 0xFF, DOUT/IE/STATUS read 0, irq_o = 0, all pads Z.
- Output drive: write DIR = 0xF0, then DOUT = 0xA5. One cycle later, pads[3:0] = 0x5 and pads[7:4] = Z.
- Input latency (no debounce, SYNC_STAGES = 2): drive pin 2 0→1 with IE = 0x04 and POL[2] = 1. Required: DIN[2] = 1 after 2 edges, STATUS = 0x04 and irq_o = 1 after 3 edges. Write STATUS = 0x04, then irq_o = 0 one cycle later.
- Simultaneous set/clear: time a W1C of bit 2 onto the exact cycle a new falling edge on pin 2 is detected, with POL[2] = 0. Required: STATUS[2] stays 1 and irq_o stays 1.
- Debounce (GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES = 4):
  - A 3-cycle high glitch on pin 0 leaves DIN[0] = 0 and STATUS = 0.
  - A held high sets DIN[0] after 2+4 edges, with STATUS[0] one edge later.
- Output-mode masking: with DIR[1] = 0 and IE = 0xFF, toggle DOUT[1] ten times. Required: STATUS = 0 and irq_o = 0 throughout.

Source files
------------

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl
//
// Registered GPIO port. Each of WIDTH pads is driven from DOUT or tristated
// according to DIR. Each pad is also sampled through a SYNC_STAGES-deep
// synchroniser, optionally debounced, and watched for edges. Edges are
// latched in a write-1-to-clear STATUS register that feeds a registered
// interrupt request.
//
// Optional build macro:
//   GPIO_DEBOUNCE_EN  - adds a per-pin stability counter between the
//                       synchroniser and the edge detector. A synchronised
//                       input must hold a new value for DEBOUNCE_CYCLES
//                       cycles before the filtered value follows it.
//                       Without the macro the filtered value is the
//                       synchronised value and DEBOUNCE_CYCLES is unused.
//
// Parameters:
//   WIDTH           - number of pins (1..32)
//   SYNC_STAGES     - synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES - stable cycles required by the filter (>= 1)
//
// Ports:
//   clk_i    in    1      clock for all logic
//   rst_i    in    1      synchronous active-high reset
//   dio_buf  inout WIDTH  pad connections
//   we_i     in    1      register write strobe
//   addr_i   in    3      register address for write and read
//   wdata_i  in    WIDTH  write data
//   rdata_o  out   WIDTH  read data, combinational from addr_i
//   irq_o    out   1      registered OR of (STATUS & IE)
//
// Register map:
//   0 DOUT    R/W  output data
//   1 DIR     R/W  1 = input (pad tristated), 0 = output
//   2 IE      R/W  interrupt enable
//   3 POL     R/W  1 = rising edge, 0 = falling edge
//   4 STATUS  R/W1C latched edges
//   5 DIN     RO   filtered input value
//   6-7       read as 0, writes ignored

module gpio_port_ctrl #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    inout  wire  [WIDTH-1:0] dio_buf,
    input  logic             we_i,
    input  logic [2:0]       addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             irq_o
);

    localparam logic [2:0] ADDR_DOUT   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_IE     = 3'd2;
    localparam logic [2:0] ADDR_POL    = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_DIN    = 3'd5;

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("gpio_port_ctrl: WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gpio_port_ctrl: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("gpio_port_ctrl: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] status_q;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] filt_val;
    logic [WIDTH-1:0] filt_prev_q;
    logic [WIDTH-1:0] edge_det;

    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] ie_next;

    logic wr_dout;
    logic wr_dir;
    logic wr_ie;
    logic wr_pol;
    logic wr_status;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_dout   = we_i && (addr_i == ADDR_DOUT);
    assign wr_dir    = we_i && (addr_i == ADDR_DIR);
    assign wr_ie     = we_i && (addr_i == ADDR_IE);
    assign wr_pol    = we_i && (addr_i == ADDR_POL);
    assign wr_status = we_i && (addr_i == ADDR_STATUS);

    // ------------------------------------------------------------------
    // Pad drive: input-mode pins are released to high impedance
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign dio_buf[i] = dir_q[i] ? 1'bz : dout_q[i];
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= dio_buf;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Optional debounce filter
    // ------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // The counter runs only while the synchronised value disagrees with the
    // filtered one; any return to agreement restarts the count, so a pulse
    // shorter than DEBOUNCE_CYCLES never reaches the filtered output. The
    // count stops at CNT_LAST and cannot wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_val[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= CNT_LAST) begin
                    filt_q[i] <= sync_val[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign filt_val = filt_q;
`else
    assign filt_val = sync_val;
`endif

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_prev_q <= '0;
        end else begin
            filt_prev_q <= filt_val;
        end
    end

    // Output-mode pins are masked so driving DOUT never raises STATUS.
    assign edge_det = dir_q & ((pol_q  &  filt_val & ~filt_prev_q) |
                               (~pol_q & ~filt_val &  filt_prev_q));

    // ------------------------------------------------------------------
    // Next-state values shared by the registers and the interrupt
    // ------------------------------------------------------------------
    // A new edge is ORed in after the clear, so set wins over a
    // simultaneous write-1-to-clear of the same bit.
    always_comb begin
        status_clr  = wr_status ? wdata_i : '0;
        status_next = (status_q & ~status_clr) | edge_det;
        ie_next     = wr_ie ? wdata_i : ie_q;
    end

    // ------------------------------------------------------------------
    // Register file and interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q   <= '0;
            dir_q    <= '1;
            ie_q     <= '0;
            pol_q    <= '1;
            status_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (wr_dout) begin
                dout_q <= wdata_i;
            end
            if (wr_dir) begin
                dir_q <= wdata_i;
            end
            if (wr_pol) begin
                pol_q <= wdata_i;
            end
            ie_q     <= ie_next;
            status_q <= status_next;
            // Built from next-state values so a STATUS clear or an IE write
            // is reflected on irq_o at the same edge that updates them.
            irq_o    <= |(status_next & ie_next);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata_o = '0;
        case (addr_i)
            ADDR_DOUT:   rdata_o = dout_q;
            ADDR_DIR:    rdata_o = dir_q;
            ADDR_IE:     rdata_o = ie_q;
            ADDR_POL:    rdata_o = pol_q;
            ADDR_STATUS: rdata_o = status_q;
            ADDR_DIN:    rdata_o = filt_val;
            default:     rdata_o = '0;
        endcase
    end

endmodule
